wasca_hexdot_blink: RTL and testbench
=====================================

# wasca_hexdot_blink

Blink scheduler for the six hex-display decimal points. CPU software configures the dots through a small Avalon-MM slave: a static on/off value, a per-dot blink enable and a blink half-period. The block computes the live dot pattern from these settings. Its Avalon-MM master then writes the pattern into the hexdot PIO output register (offset 0) only when the pattern changes. It sits between the CPU bus and the hexdot PIO and relieves firmware of timed blink writes.

## Interface
Parameters:
- TICK_DIV, 2500000: clk cycles per blink tick (20 Hz at 50 MHz); minimum 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_address  in  2  slave register select.
- s_chipselect  in  1  slave select.
- s_write_n  in  1  slave write strobe, active-low.
- s_writedata  in  32  slave write data.
- s_readdata  out  32  slave read data, combinational from s_address (zero wait, zero latency).
- m_address  out  2  master address; constant 0.
- m_chipselect  out  1  master select.
- m_write_n  out  1  master write strobe, active-low.
- m_writedata  out  32  {26'b0, pattern[5:0]}.
- m_waitrequest  in  1  interconnect stall; tie 0 for direct PIO connection.

## Operation
Registers (write when s_chipselect & ~s_write_n):
- 0 STATIC[5:0]: static dot value.
- 1 BLINK_EN[5:0]: dots that blink.
- 2 PERIOD[7:0]: ticks per half-period; 0 treated as 1. A write also clears the tick counter.
- 3 write: bit0=1 resyncs the blink state: prescaler cleared, tick counter cleared, phase set to ON.
- 3 read: {23'b0, busy, 2'b0, last_written[5:0]}. busy = state WRITE.
- Reads of 0–2 return their register value zero-extended. Unused bits read 0.

Blink counting:
- The prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick at TICK_DIV-1, then wraps.
- On each tick the tick counter increments. When it reaches the effective PERIOD it clears and the phase toggles.

Live pattern:
- pattern = STATIC & ~(BLINK_EN & {6{phase==OFF}}).
- Blinking dots therefore follow STATIC during ON and are forced 0 during OFF.

Master FSM:
- IDLE:
  - Samples pattern.
  - If pattern != last_written, latches pattern into m_writedata and goes to WRITE.
- WRITE:
  - m_chipselect=1, m_write_n=0. Address and data are held stable.
  - When m_waitrequest=0, sets last_written=m_writedata and returns to IDLE.
- Pattern changes during WRITE do not alter the transfer in flight. The next IDLE cycle compares again and issues a follow-up write if needed. Intermediate values may be skipped; the final value is always written.

Reset values:
- All registers and last_written are 0; phase is ON; state is IDLE.
- m_chipselect=0, m_write_n=1, m_writedata=0, m_address=0.
- last_written=0 matches the PIO reset value, so no write occurs after reset until the pattern becomes nonzero.

## Timing
- A slave write at edge N updates the register at N.
- pattern is valid combinationally after N. The FSM sees it at edge N+1 and drives m_chipselect during cycle N+1..N+2.
- With m_waitrequest=0, the PIO captures at edge N+2. The total register-write to PIO update latency is 2 cycles.
- A phase toggle on the tick edge T gives a master write completing at T+2.
- Back-to-back changes: at least one IDLE cycle separates consecutive master writes, so the minimum spacing is 2 cycles.
- A resync on the same edge as a tick: the resync wins and the phase becomes ON.
- A PERIOD write on the same edge as a phase-toggling tick: the counter clears and the toggle still occurs.
- Reset asserted during WRITE:
  - m_chipselect drops asynchronously and last_written returns to 0.
  - The PIO has also reset, so the two stay consistent.

## Test plan
All scenarios use TICK_DIV=4.

- Reset release, no writes -> m_chipselect stays 0 for 100 cycles; status reads 0x000.
- Write STATIC=0x2A -> exactly one master write of 0x2A, captured 2 cycles after the slave write; status reads 0x02A after completion.
- STATIC=0x3F, BLINK_EN=0x05, PERIOD=2 -> master writes alternate 0x3A/0x3F every 8 cycles; no other writes.
- Hold m_waitrequest=1 for 5 cycles during a write -> address and data stable throughout; busy=1; exactly one completion.
- A STATIC change while a write is stalled -> the stalled write completes with the old value and the next write carries the new value.
- While phase is OFF: write reg3=1 -> pattern returns to STATIC within 2 cycles; the next toggle occurs 8 cycles after resync. Assert reset during WRITE -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/wasca_hexdot_blink.sv
// Blink scheduler for the six hex-display decimal points: a CPU-facing register
// slave computes the live dot pattern, and a master pushes it to the PIO on change.
module wasca_hexdot_blink #(
  parameter int TICK_DIV = 2500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t         state, state_nxt;
  logic [5:0]     static_r, blink_en, last_written, wr_data;
  logic [7:0]     period, eff_period, tick_cnt;
  logic [PW-1:0]  presc;
  logic           phase_off, tick, period_done, load, done;
  logic           wr_en, wr_period, resync;
  logic [5:0]     pattern;
  logic           unused_wdata;

  assign unused_wdata = ^s_writedata[31:8];

  assign wr_en     = s_chipselect & ~s_write_n;
  assign wr_period = wr_en && (s_address == 2'd2);
  assign resync    = wr_en && (s_address == 2'd3) && s_writedata[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      static_r <= '0;
      blink_en <= '0;
      period   <= '0;
    end else if (wr_en) begin
      case (s_address)
        2'd0:    static_r <= s_writedata[5:0];
        2'd1:    blink_en <= s_writedata[5:0];
        2'd2:    period   <= s_writedata[7:0];
        default: ;
      endcase
    end
  end

  assign tick        = (presc == PW'(TICK_DIV - 1));
  assign eff_period  = (period == 8'd0) ? 8'd1 : period;
  assign period_done = tick && (({1'b0, tick_cnt} + 9'd1) >= {1'b0, eff_period});

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                presc <= '0;
    else if (resync || tick)  presc <= '0;
    else                      presc <= presc + PW'(1);
  end

  // Resync overrides everything; a PERIOD write clears the count but lets a
  // coincident toggle through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt  <= '0;
      phase_off <= 1'b0;
    end else if (resync) begin
      tick_cnt  <= '0;
      phase_off <= 1'b0;
    end else begin
      if (period_done) begin
        tick_cnt  <= '0;
        phase_off <= ~phase_off;
      end else if (tick) begin
        tick_cnt  <= tick_cnt + 8'd1;
      end
      if (wr_period) tick_cnt <= '0;
    end
  end

  assign pattern = static_r & ~(blink_en & {6{phase_off}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    done         = 1'b0;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    case (state)
      S_IDLE: if (pattern != last_written) begin
        load      = 1'b1;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        if (!m_waitrequest) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Data is frozen at launch so a stalled transfer never changes mid-flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_data      <= '0;
      last_written <= '0;
    end else begin
      if (load) wr_data      <= pattern;
      if (done) last_written <= wr_data;
    end
  end

  assign m_address   = 2'd0;
  assign m_writedata = {26'b0, wr_data};

  always_comb begin
    s_readdata = '0;
    case (s_address)
      2'd0: s_readdata = {26'b0, static_r};
      2'd1: s_readdata = {26'b0, blink_en};
      2'd2: s_readdata = {24'b0, period};
      2'd3: s_readdata = {23'b0, (state == S_WRITE), 2'b0, last_written};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wasca_hexdot_blink.sv
// Randomized and directed bench for wasca_hexdot_blink against an event-count
// reference model and a behavioural PIO capture register.
module tb_wasca_hexdot_blink;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  s_address;
  logic        s_chipselect, s_write_n;
  logic [31:0] s_writedata, s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect, m_write_n, m_waitrequest;
  logic [31:0] m_writedata;

  wasca_hexdot_blink #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // reference model: edges since resync, ticks since last count clear, phase
  int         since_sync, nticks, nwr;
  bit         m_off;
  logic [5:0] m_static, m_blink, pio;
  logic [7:0] m_period;
  logic [5:0] hist[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] model_pat();
    return m_static & ~(m_blink & {6{m_off}});
  endfunction

  task automatic model_reset();
    since_sync = 0; nticks = 0; m_off = 0;
    m_static = '0; m_blink = '0; m_period = '0; pio = '0;
  endtask

  task automatic model_edge();
    int eff;
    eff = (m_period == 0) ? 1 : int'(m_period);
    since_sync++;
    if (since_sync % TICK_DIV == 0) begin
      nticks++;
      if (nticks >= eff) begin nticks = 0; m_off = !m_off; end
    end
    if (s_chipselect && !s_write_n) begin
      case (s_address)
        2'd0: m_static = s_writedata[5:0];
        2'd1: m_blink  = s_writedata[5:0];
        2'd2: begin m_period = s_writedata[7:0]; nticks = 0; end
        default: if (s_writedata[0]) begin since_sync = 0; nticks = 0; m_off = 0; end
      endcase
    end
    hist.push_back(model_pat());
  endtask

  // One clock: PIO captures what the master presented during the cycle.
  task automatic cyc();
    logic       cap;
    logic [5:0] capd;
    cap  = m_chipselect && !m_write_n && !m_waitrequest;
    capd = m_writedata[5:0];
    @(posedge clk);
    model_edge();
    if (cap) begin pio = capd; nwr++; end
    @(negedge clk);
  endtask

  task automatic bus_wr(logic [1:0] a, logic [31:0] d);
    s_address = a; s_chipselect = 1'b1; s_write_n = 1'b0; s_writedata = d;
    cyc();
    s_chipselect = 1'b0; s_write_n = 1'b1;
  endtask

  task automatic rd(logic [1:0] a, output logic [31:0] d);
    s_address = a;
    #1 d = s_readdata;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a0, d0;
    int          n0, cs_seen, rs, k;
    nwr = 0;
    reset = 1'b1; s_address = '0; s_chipselect = 0; s_write_n = 1;
    s_writedata = '0; m_waitrequest = 0;
    model_reset();
    #1;
    check("rst_cs", 32'(m_chipselect), 0);
    check("rst_wn", 32'(m_write_n), 1);
    check("rst_wd", m_writedata, 0);
    check("rst_addr", 32'(m_address), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // idle after reset: no master activity
    cs_seen = 0;
    repeat (100) begin cyc(); if (m_chipselect) cs_seen++; end
    check("idle_cs", 32'(cs_seen), 0);
    rd(2'd3, r); check("idle_status", r, 32'h000);

    // single static write, 2-cycle latency
    n0 = nwr;
    bus_wr(2'd0, 32'h2A);
    cyc(); check("lat_n1", 32'(pio), 0);
    cyc(); check("lat_n2", 32'(pio), 32'h2A);
    repeat (10) cyc();
    check("one_write", 32'(nwr - n0), 1);
    rd(2'd3, r); check("status_2a", r, 32'h02A);

    // blinking: 0x3F / 0x3A every 8 cycles
    bus_wr(2'd0, 32'h3F);
    bus_wr(2'd2, 32'd2);
    bus_wr(2'd3, 32'd1);
    rs = hist.size();
    bus_wr(2'd1, 32'h05);
    n0 = nwr;
    while (hist.size() < rs + 41) begin
      if (hist.size() == rs + 3)  n0 = nwr;
      if (hist.size() == rs + 35) check("blink_cnt", 32'(nwr - n0), 4);
      cyc();
      if (hist.size() >= rs + 3) check("blink_dly", 32'(pio), 32'(hist[hist.size()-3]));
      if (hist.size() == rs + 10) check("blink_off", 32'(pio), 32'h3A);
      if (hist.size() == rs + 18) check("blink_on", 32'(pio), 32'h3F);
    end

    // stalled write, with a STATIC change while stalled
    bus_wr(2'd1, 32'h0);
    repeat (6) cyc();
    m_waitrequest = 1'b1;
    bus_wr(2'd0, 32'h11);
    cyc();
    a0 = 32'(m_address); d0 = m_writedata;
    check("stall_data", d0, 32'h11);
    check("stall_cs", 32'(m_chipselect), 1);
    rd(2'd3, r); check("stall_busy", 32'(r[8]), 1);
    bus_wr(2'd0, 32'h22);
    k = 0;
    repeat (3) begin
      cyc();
      if (m_address !== a0[1:0] || m_writedata !== d0 || !m_chipselect || m_write_n) k++;
    end
    check("stall_stable", 32'(k), 0);
    n0 = nwr;
    m_waitrequest = 1'b0;
    cyc(); check("stall_old", 32'(pio), 32'h11);
    repeat (3) cyc();
    check("stall_new", 32'(pio), 32'h22);
    check("stall_cnt", 32'(nwr - n0), 2);
    rd(2'd3, r); check("status_22", r, 32'h022);

    // resync while phase is OFF
    bus_wr(2'd0, 32'h3F);
    bus_wr(2'd1, 32'h3F);
    bus_wr(2'd2, 32'd2);
    k = 0;
    while (!m_off && k < 100) begin cyc(); k++; end
    check("off_reached", 32'(m_off), 1);
    repeat (3) cyc();
    check("off_pio", 32'(pio), 0);
    bus_wr(2'd3, 32'd1);
    rs = hist.size();
    cyc(); cyc();
    check("resync_pio", 32'(pio), 32'h3F);
    while (hist.size() < rs + 9) cyc();
    check("resync_hold", 32'(pio), 32'h3F);
    cyc();
    check("resync_toggle", 32'(pio), 0);

    // reset asserted during a stalled write
    m_waitrequest = 1'b1;
    bus_wr(2'd1, 32'h0);
    bus_wr(2'd0, 32'h15);
    cyc();
    check("pre_rst_cs", 32'(m_chipselect), 1);
    #2 reset = 1'b1;
    #1;
    check("arst_cs", 32'(m_chipselect), 0);
    check("arst_wn", 32'(m_write_n), 1);
    check("arst_wd", m_writedata, 0);
    rd(2'd3, r); check("arst_status", r, 0);
    @(negedge clk);
    reset = 1'b0;
    m_waitrequest = 1'b0;
    model_reset();

    // randomized register traffic with random stalls
    for (int rnd = 0; rnd < 12; rnd++) begin
      repeat (30) begin
        m_waitrequest = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) begin
          k = $urandom_range(0, 3);
          case (k)
            0, 1: bus_wr(2'(k), $urandom);
            2:    bus_wr(2'd2, {$urandom_range(0, 255) > 200 ? 24'($urandom) : 24'h0,
                               8'($urandom_range(0, 3))});
            default: bus_wr(2'd3, 32'($urandom_range(0, 1)));
          endcase
        end else cyc();
      end
      m_waitrequest = 1'b0;
      bus_wr(2'd1, 32'h0);
      repeat (6) cyc();
      check("rnd_pio", 32'(pio), 32'(model_pat()));
      rd(2'd3, r); check("rnd_status", r, 32'(model_pat()));
      rd(2'd0, r); check("rnd_reg0", r, 32'(m_static));
      rd(2'd2, r); check("rnd_reg2", r, 32'(m_period));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
